// File: rtl/io_responder_if.sv
// Memory-bus view of the I/O window: the CPU initiates address/data/strobe and
// the responder returns the window hit plus combinational read data.
interface io_responder_if;
  logic [15:0] Addr;
  logic [15:0] Data;
  logic        Mem_Write;
  logic        io_hit;
  logic [15:0] Rd_Data;

  modport master (output Addr, Data, Mem_Write, input io_hit, Rd_Data);
  modport slave  (input Addr, Data, Mem_Write, output io_hit, Rd_Data);
endinterface

// File: rtl/io_responder.sv
// 8-word memory-mapped I/O responder: GPIO out, synchronized GPIO in with edge
// capture, and an optional compare timer built only when IO_TIMER_EN is defined.
module io_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic          CLK,
  input  logic          RST,
  io_responder_if.slave bus,
  input  logic [15:0]   gpio_in,
  output logic [15:0]   gpio_out,
  output logic          irq
);

  typedef enum logic [2:0] {
    OFF_GPIO_OUT  = 3'd0,
    OFF_GPIO_IN   = 3'd1,
    OFF_EDGE_STAT = 3'd2,
    OFF_EDGE_MASK = 3'd3,
    OFF_TMR_CTRL  = 3'd4,
    OFF_TMR_CMP   = 3'd5,
    OFF_TMR_CNT   = 3'd6,
    OFF_STATUS    = 3'd7
  } io_off_t;

  logic        wr;
  logic        wr_gpio_out;
  logic        wr_edge_stat;
  logic        wr_edge_mask;

  logic [15:0] gpio_out_q;
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;
  logic [15:0] prev_q;
  logic [15:0] edge_stat_q;
  logic [15:0] edge_mask_q;
  logic [15:0] rise;
  logic [15:0] w1c_mask;
  logic        irq_q;

  // Timer-side values seen by the read mux and interrupt; constant without the timer.
  logic        tmr_irq;
  logic        tf_rd;
  logic [15:0] tmr_ctrl_rd;
  logic [15:0] tmr_cmp_rd;
  logic [15:0] tmr_cnt_rd;

  assign bus.io_hit   = (bus.Addr[15:3] == BASE_ADDR[15:3]);
  assign wr           = bus.Mem_Write & bus.io_hit;
  assign wr_gpio_out  = wr && (bus.Addr[2:0] == OFF_GPIO_OUT);
  assign wr_edge_stat = wr && (bus.Addr[2:0] == OFF_EDGE_STAT);
  assign wr_edge_mask = wr && (bus.Addr[2:0] == OFF_EDGE_MASK);

  assign rise     = sync2_q & ~prev_q;
  assign w1c_mask = wr_edge_stat ? bus.Data : 16'd0;

  always_ff @(posedge CLK) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values, e.g. the sync chain shifts by exactly one stage per clock.
    if (RST) begin
      gpio_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      edge_stat_q <= '0;
      edge_mask_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      // OR-ing rise after the clear lets a same-cycle edge win over W1C.
      edge_stat_q <= (edge_stat_q & ~w1c_mask) | rise;
      if (wr_gpio_out)  gpio_out_q  <= bus.Data;
      if (wr_edge_mask) edge_mask_q <= bus.Data;
      irq_q       <= (|(edge_stat_q & edge_mask_q)) | tmr_irq;
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = irq_q;

  always_comb begin
    // NOTE: default first so every path assigns Rd_Data and no latch is inferred.
    bus.Rd_Data = '0;
    if (bus.io_hit) begin
      case (bus.Addr[2:0])
        OFF_GPIO_OUT:  bus.Rd_Data = gpio_out_q;
        OFF_GPIO_IN:   bus.Rd_Data = sync2_q;
        OFF_EDGE_STAT: bus.Rd_Data = edge_stat_q;
        OFF_EDGE_MASK: bus.Rd_Data = edge_mask_q;
        OFF_TMR_CTRL:  bus.Rd_Data = tmr_ctrl_rd;
        OFF_TMR_CMP:   bus.Rd_Data = tmr_cmp_rd;
        OFF_TMR_CNT:   bus.Rd_Data = tmr_cnt_rd;
        OFF_STATUS:    bus.Rd_Data = {14'd0, irq_q, tf_rd};
        default:       bus.Rd_Data = '0;
      endcase
    end
  end

`ifdef IO_TIMER_EN
  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_t;

  tmr_state_t  tmr_state_q;
  tmr_state_t  tmr_state_d;
  logic        tmr_auto_q;
  logic        tmr_tie_q;
  logic [15:0] tmr_cmp_q;
  logic [15:0] tmr_cnt_q;
  logic [15:0] tmr_cnt_d;
  logic        tf_q;
  logic        tf_d;
  logic        tmr_match;
  logic        wr_ctrl;
  logic        wr_cmp;
  logic        wr_cnt;
  logic        wr_status;

  assign wr_ctrl   = wr && (bus.Addr[2:0] == OFF_TMR_CTRL);
  assign wr_cmp    = wr && (bus.Addr[2:0] == OFF_TMR_CMP);
  assign wr_cnt    = wr && (bus.Addr[2:0] == OFF_TMR_CNT);
  assign wr_status = wr && (bus.Addr[2:0] == OFF_STATUS);
  assign tmr_match = (tmr_state_q == TMR_RUN) && (tmr_cnt_q == tmr_cmp_q);

  always_ff @(posedge CLK) begin
    if (RST) tmr_state_q <= TMR_IDLE;
    else     tmr_state_q <= tmr_state_d;
  end

  // A CTRL write beats the one-shot self-disable.
  always_comb begin
    tmr_state_d = tmr_state_q;
    if (wr_ctrl)                        tmr_state_d = bus.Data[0] ? TMR_RUN : TMR_IDLE;
    else if (tmr_match && !tmr_auto_q)  tmr_state_d = TMR_IDLE;
  end

  always_comb begin
    tmr_cnt_d = tmr_cnt_q;
    tf_d      = tf_q;
    if (tmr_match)                   tmr_cnt_d = tmr_auto_q ? 16'd0 : tmr_cnt_q;
    else if (tmr_state_q == TMR_RUN) tmr_cnt_d = tmr_cnt_q + 16'd1;
    if (wr_cnt)                      tmr_cnt_d = bus.Data;
    if (wr_status && bus.Data[0])    tf_d      = 1'b0;
    if (tmr_match)                   tf_d      = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr_auto_q <= 1'b0;
      tmr_tie_q  <= 1'b0;
      tmr_cmp_q  <= '0;
      tmr_cnt_q  <= '0;
      tf_q       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        tmr_auto_q <= bus.Data[1];
        tmr_tie_q  <= bus.Data[2];
      end
      if (wr_cmp) tmr_cmp_q <= bus.Data;
      tmr_cnt_q <= tmr_cnt_d;
      tf_q      <= tf_d;
    end
  end

  assign tmr_irq     = tf_q & tmr_tie_q;
  assign tf_rd       = tf_q;
  assign tmr_ctrl_rd = {13'd0, tmr_tie_q, tmr_auto_q, tmr_state_q == TMR_RUN};
  assign tmr_cmp_rd  = tmr_cmp_q;
  assign tmr_cnt_rd  = tmr_cnt_q;
`else
  assign tmr_irq     = 1'b0;
  assign tf_rd       = 1'b0;
  assign tmr_ctrl_rd = '0;
  assign tmr_cmp_rd  = '0;
  assign tmr_cnt_rd  = '0;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed register-map scenarios plus a
// randomized bus/GPIO run compared every cycle against a register-level model.
module tb_io_responder;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic        irq;

  io_responder_if bus ();

  io_responder #(.BASE_ADDR(BASE)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #10 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Register-level model: what software would read back after each clock.
  logic [15:0] m_gpo, m_stat, m_mask;
  logic [15:0] m_hist [1:3];  // gpio_in as sampled 1, 2, 3 edges ago
  logic        m_irq, m_tf;
`ifdef IO_TIMER_EN
  logic        m_en, m_auto, m_tie;
  logic [15:0] m_cmp, m_cnt;
`endif

  logic [15:0] cur_gin  = '0;
  logic        last_hit;
  logic [15:0] last_rd;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_window(input logic [15:0] a);
    return (a >= BASE) && (a <= BASE + 16'd7);
  endfunction

  task automatic model_reset();
    m_gpo = '0; m_stat = '0; m_mask = '0; m_irq = 1'b0; m_tf = 1'b0;
    for (int i = 1; i <= 3; i++) m_hist[i] = '0;
`ifdef IO_TIMER_EN
    m_en = 1'b0; m_auto = 1'b0; m_tie = 1'b0; m_cmp = '0; m_cnt = '0;
`endif
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (!in_window(a)) return 16'd0;
    case (a - BASE)
      16'd0: return m_gpo;
      16'd1: return m_hist[2];
      16'd2: return m_stat;
      16'd3: return m_mask;
`ifdef IO_TIMER_EN
      16'd4: return {13'd0, m_tie, m_auto, m_en};
      16'd5: return m_cmp;
      16'd6: return m_cnt;
`endif
      16'd7: return {14'd0, m_irq, m_tf};
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_step(input logic [15:0] a, input logic [15:0] d, input logic w,
                            input logic [15:0] gin, input logic rst);
    logic        wr;
    logic [15:0] o, rise, clr;
    logic        irq_n;
`ifdef IO_TIMER_EN
    logic        matched;
`endif
    if (rst) begin
      model_reset();
      return;
    end
    wr    = w && in_window(a);
    o     = a - BASE;
    irq_n = |(m_stat & m_mask);
`ifdef IO_TIMER_EN
    irq_n = irq_n | (m_tf & m_tie);
`endif
    rise   = m_hist[2] & ~m_hist[3];
    clr    = (wr && o == 16'd2) ? d : 16'd0;
    m_stat = (m_stat & ~clr) | rise;
    m_hist[3] = m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = gin;
    if (wr && o == 16'd0) m_gpo  = d;
    if (wr && o == 16'd3) m_mask = d;
`ifdef IO_TIMER_EN
    matched = m_en && (m_cnt == m_cmp);
    if (wr && o == 16'd7 && d[0]) m_tf = 1'b0;
    if (matched) begin
      m_tf = 1'b1;
      if (m_auto) m_cnt = 16'd0;
      else        m_en  = 1'b0;
    end else if (m_en) begin
      m_cnt = m_cnt + 16'd1;
    end
    if (wr && o == 16'd6) m_cnt = d;
    if (wr && o == 16'd5) m_cmp = d;
    if (wr && o == 16'd4) {m_tie, m_auto, m_en} = d[2:0];
`endif
    m_irq = irq_n;
  endtask

  // One bus cycle: drive after the falling edge, check combinational outputs,
  // advance the model at the rising edge, check registered outputs after it.
  task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic [15:0] gin, input logic rst);
    bus.Addr = a; bus.Data = d; bus.Mem_Write = w; gpio_in = gin; RST = rst;
    #1;
    last_hit = bus.io_hit;
    last_rd  = bus.Rd_Data;
    check("io_hit", {15'd0, last_hit}, {15'd0, in_window(a)});
    check("rd_data", last_rd, model_read(a));
    @(posedge CLK);
    model_step(a, d, w, gin, rst);
    @(negedge CLK);
    check("gpio_out", gpio_out, m_gpo);
    check("irq", {15'd0, irq}, {15'd0, m_irq});
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [15:0] d);
    cycle(BASE + {13'd0, off}, d, 1'b1, cur_gin, 1'b0);
  endtask

  task automatic idle();
    cycle(BASE + 16'($urandom_range(0, 7)), 16'($urandom), 1'b0, cur_gin, 1'b0);
  endtask

  // Literal read-back between cycles; at most four per low phase.
  task automatic peek(input logic [2:0] off, input logic [15:0] mask,
                      input logic [15:0] exp, input string name);
    bus.Addr = BASE + {13'd0, off};
    bus.Mem_Write = 1'b0;
    #1;
    check(name, bus.Rd_Data & mask, exp);
  endtask

  initial begin
    bus.Addr = '0; bus.Data = '0; bus.Mem_Write = 1'b0;
    model_reset();
    cycle(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    cycle(BASE, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
    check("reset_gpio_out", gpio_out, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);

    // Decode
    wr_reg(3'd0, 16'hA5A5);
    check("dec_gpio_out", gpio_out, 16'hA5A5);
    cycle(16'hFEFF, 16'h1234, 1'b1, cur_gin, 1'b0);
    check("dec_below_hit", {15'd0, last_hit}, 16'h0000);
    check("dec_below_rd", last_rd, 16'h0000);
    check("dec_below_gpio", gpio_out, 16'hA5A5);
    cycle(16'hFF08, 16'h1234, 1'b1, cur_gin, 1'b0);
    check("dec_above_hit", {15'd0, last_hit}, 16'h0000);
    check("dec_above_rd", last_rd, 16'h0000);
    check("dec_above_gpio", gpio_out, 16'hA5A5);

    // Edge capture: input change -> STAT after 3 edges, irq after 4
    wr_reg(3'd3, 16'h0001);
    cur_gin = 16'h0001;
    idle();
    idle();
    peek(3'd1, 16'hFFFF, 16'h0001, "gpio_in_sync2");
    peek(3'd2, 16'hFFFF, 16'h0000, "edge_stat_e2");
    idle();
    peek(3'd2, 16'hFFFF, 16'h0001, "edge_stat_e3");
    check("edge_irq_e3", {15'd0, irq}, 16'h0000);
    idle();
    check("edge_irq_e4", {15'd0, irq}, 16'h0001);

    // W1C: STAT clears at once, irq a cycle later
    wr_reg(3'd2, 16'h0001);
    peek(3'd2, 16'hFFFF, 16'h0000, "w1c_stat");
    check("w1c_irq_hold", {15'd0, irq}, 16'h0001);
    idle();
    check("w1c_irq_drop", {15'd0, irq}, 16'h0000);

    // New edge on the same edge as the clear: set wins
    cur_gin = 16'h0000;
    repeat (3) idle();
    cur_gin = 16'h0001;
    idle();
    idle();
    wr_reg(3'd2, 16'h0001);
    peek(3'd2, 16'hFFFF, 16'h0001, "w1c_set_wins");
    wr_reg(3'd2, 16'h0001);
    peek(3'd2, 16'hFFFF, 16'h0000, "w1c_after");
    wr_reg(3'd3, 16'h0000);

`ifdef IO_TIMER_EN
    // One-shot: CMP=5, CNT=0, CTRL=EN|TIE
    wr_reg(3'd5, 16'd5);
    wr_reg(3'd6, 16'd0);
    wr_reg(3'd4, 16'h0005);
    repeat (5) idle();
    peek(3'd6, 16'hFFFF, 16'd5, "os_cnt_e5");
    peek(3'd7, 16'hFFFF, 16'h0000, "os_tf_e5");
    idle();
    peek(3'd7, 16'hFFFF, 16'h0001, "os_tf_e6");
    peek(3'd4, 16'hFFFF, 16'h0004, "os_en_clear");
    peek(3'd6, 16'hFFFF, 16'd5, "os_cnt_hold");
    idle();
    check("os_irq_e7", {15'd0, irq}, 16'h0001);
    peek(3'd7, 16'hFFFF, 16'h0003, "os_status_e7");

    // Auto-reload: CMP=3, CTRL=EN|AUTO
    begin
      logic [15:0] seq [8];
      seq = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
      wr_reg(3'd4, 16'h0000);
      wr_reg(3'd7, 16'h0001);
      wr_reg(3'd5, 16'd3);
      wr_reg(3'd6, 16'd0);
      wr_reg(3'd4, 16'h0003);
      for (int k = 0; k < 8; k++) begin
        idle();
        peek(3'd6, 16'hFFFF, seq[k], "auto_cnt");
        if (k == 2) peek(3'd7, 16'h0001, 16'h0000, "auto_tf_before");
        if (k == 3) peek(3'd7, 16'h0001, 16'h0001, "auto_tf_set");
      end
    end

    // CNT write while running overrides the increment and wraps
    wr_reg(3'd4, 16'h0000);
    wr_reg(3'd7, 16'h0001);
    wr_reg(3'd5, 16'd2);
    wr_reg(3'd6, 16'd0);
    wr_reg(3'd4, 16'h0003);
    wr_reg(3'd6, 16'hFFFF);
    peek(3'd6, 16'hFFFF, 16'hFFFF, "wrap_load");
    for (int k = 0; k < 3; k++) begin
      idle();
      peek(3'd6, 16'hFFFF, 16'(k), "wrap_cnt");
      peek(3'd7, 16'h0001, 16'h0000, "wrap_tf_before");
    end
    idle();
    peek(3'd7, 16'h0001, 16'h0001, "wrap_tf_set");
    peek(3'd6, 16'hFFFF, 16'd0, "wrap_reload");
    wr_reg(3'd4, 16'h0000);
    wr_reg(3'd7, 16'h0001);
`else
    // Without the timer, offsets 4-6 and TF are absent
    wr_reg(3'd4, 16'hFFFF);
    wr_reg(3'd5, 16'hFFFF);
    wr_reg(3'd6, 16'hFFFF);
    wr_reg(3'd7, 16'hFFFF);
    peek(3'd4, 16'hFFFF, 16'h0000, "notmr_ctrl");
    peek(3'd5, 16'hFFFF, 16'h0000, "notmr_cmp");
    peek(3'd6, 16'hFFFF, 16'h0000, "notmr_cnt");
    peek(3'd7, 16'h0001, 16'h0000, "notmr_tf");
`endif

    // Randomized bus traffic, GPIO toggles and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a, d;
      logic        w;
      int          r;
      if ($urandom_range(0, 299) == 0) begin
        cycle(BASE + 16'($urandom_range(0, 7)), 16'($urandom), 1'b1, cur_gin, 1'b1);
        continue;
      end
      if ($urandom_range(0, 5) == 0) cur_gin = cur_gin ^ (16'h0001 << $urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = BASE + 16'($urandom_range(0, 7));
      else if (r == 7) a = BASE - 16'($urandom_range(1, 16));
      else if (r == 8) a = BASE + 16'($urandom_range(8, 40));
      else             a = 16'($urandom);
      w = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      cycle(a, d, w, cur_gin, 1'b0);
    end

    // Mid-run reset: everything reads 0, GPIO_IN resumes after two edges
    cur_gin = 16'h5A3C;
    cycle(BASE, 16'hFFFF, 1'b1, cur_gin, 1'b1);
    check("mid_rst_gpio_out", gpio_out, 16'h0000);
    check("mid_rst_irq", {15'd0, irq}, 16'h0000);
    for (int k = 0; k < 4; k++) peek(3'(k), 16'hFFFF, 16'h0000, "mid_rst_read_lo");
    cycle(BASE + 16'd1, 16'h0000, 1'b0, cur_gin, 1'b0);
    for (int k = 4; k < 8; k++) peek(3'(k), 16'hFFFF, 16'h0000, "mid_rst_read_hi");
    cycle(BASE + 16'd1, 16'h0000, 1'b0, cur_gin, 1'b0);
    peek(3'd1, 16'hFFFF, 16'h5A3C, "mid_rst_gpio_in");
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
